// File: rtl/wb_debug_master.sv
// Byte-stream to Wishbone bridge: parses 'W'/'R' command frames from a UART byte
// interface, runs one single-beat bus cycle per frame and streams back the response.
module wb_debug_master #(
   parameter int ACK_TIMEOUT   = 1024,
   parameter int FRAME_TIMEOUT = 500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] m_wb_addr,
   output logic [31:0] m_wb_dat_o,
   input  logic [31:0] m_wb_dat_i,
   output logic        m_wb_we,
   output logic [3:0]  m_wb_sel,
   output logic        m_wb_cyc,
   output logic        m_wb_stb,
   input  logic        m_wb_ack,
   input  logic        m_wb_err,
   output logic        busy
);

   localparam int CNT_MAX = (ACK_TIMEOUT > FRAME_TIMEOUT) ? ACK_TIMEOUT : FRAME_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ADDR  = 3'd1;
   localparam logic [2:0] WDATA = 3'd2;
   localparam logic [2:0] BUS   = 3'd3;
   localparam logic [2:0] RESP  = 3'd4;

   localparam logic [7:0] CMD_W   = 8'h57;
   localparam logic [7:0] CMD_R   = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [2:0]       state_r;
   logic             op_write_r;
   logic [1:0]       byte_cnt_r;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      rdata_r;
   logic [2:0]       resp_left_r;

   assign m_wb_sel = 4'hF;

   // Frame parser, bus cycle sequencer and response serializer in one state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         op_write_r  <= 1'b0;
         byte_cnt_r  <= 2'd0;
         cnt_r       <= {CNT_W{1'b0}};
         rdata_r     <= 32'h0000_0000;
         resp_left_r <= 3'd0;
         tx_data     <= 8'h00;
         tx_valid    <= 1'b0;
         m_wb_addr   <= 32'h0000_0000;
         m_wb_dat_o  <= 32'h0000_0000;
         m_wb_we     <= 1'b0;
         m_wb_cyc    <= 1'b0;
         m_wb_stb    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (rx_valid && (rx_data == CMD_W || rx_data == CMD_R)) begin
                  op_write_r <= (rx_data == CMD_W);
                  byte_cnt_r <= 2'd0;
                  cnt_r      <= {CNT_W{1'b0}};
                  state_r    <= ADDR;
                  busy       <= 1'b1;
               end
            end
            ADDR: begin
               if (rx_valid) begin
                  m_wb_addr  <= {m_wb_addr[23:0], rx_data};
                  cnt_r      <= {CNT_W{1'b0}};
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_cnt_r == 2'd3) begin
                     state_r <= op_write_r ? WDATA : BUS;
                  end
               end else if (cnt_r == FRAME_LAST) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            WDATA: begin
               if (rx_valid) begin
                  m_wb_dat_o <= {m_wb_dat_o[23:0], rx_data};
                  cnt_r      <= {CNT_W{1'b0}};
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_cnt_r == 2'd3) begin
                     state_r <= BUS;
                  end
               end else if (cnt_r == FRAME_LAST) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            BUS: begin
               // The first BUS cycle only launches the strobe; stb then doubles as "cycle in flight".
               if (!m_wb_stb) begin
                  m_wb_cyc <= 1'b1;
                  m_wb_stb <= 1'b1;
                  m_wb_we  <= op_write_r;
                  cnt_r    <= {CNT_W{1'b0}};
               end else if (m_wb_err || m_wb_ack || cnt_r == ACK_LAST) begin
                  m_wb_cyc <= 1'b0;
                  m_wb_stb <= 1'b0;
                  m_wb_we  <= 1'b0;
                  cnt_r    <= {CNT_W{1'b0}};
                  tx_valid <= 1'b1;
                  state_r  <= RESP;
                  if (m_wb_ack && !m_wb_err) begin
                     tx_data     <= RSP_OK;
                     resp_left_r <= op_write_r ? 3'd0 : 3'd4;
                     if (!op_write_r) begin
                        rdata_r <= m_wb_dat_i;
                     end
                  end else begin
                     tx_data     <= RSP_ERR;
                     resp_left_r <= 3'd0;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            RESP: begin
               if (tx_ready) begin
                  if (resp_left_r == 3'd0) begin
                     tx_valid <= 1'b0;
                     state_r  <= IDLE;
                     busy     <= 1'b0;
                  end else begin
                     tx_data     <= rdata_r[31:24];
                     rdata_r     <= {rdata_r[23:0], 8'h00};
                     resp_left_r <= resp_left_r - 3'd1;
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               tx_valid <= 1'b0;
               m_wb_cyc <= 1'b0;
               m_wb_stb <= 1'b0;
               m_wb_we  <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
